// File: rtl/debug_sender_pkg.sv
// Shared definitions for the debug frame sender: FSM encoding, word geometry
// and the layout of the frame (PC, then register file, then data memory).
package debug_sender_pkg;

    typedef enum logic [5:0] {
        ST_IDLE     = 6'b000001,
        ST_LOAD     = 6'b000010,
        ST_SEND     = 6'b000100,
        ST_WAIT_TX  = 6'b001000,
        ST_DONE     = 6'b010000,
        ST_WAIT_LOW = 6'b100000
    } dbg_state_e;

    localparam int DBG_NBITS      = 32;
    localparam int DBG_NREGS      = 32;
    localparam int DBG_DM_WORDS   = 32;
    localparam int BYTES_PER_WORD = DBG_NBITS / 8;

    localparam int PC_IDX  = 0;
    localparam int RF_BASE = 1;
    localparam int DM_BASE = RF_BASE + DBG_NREGS;

    function automatic int bytes_per_word(input int nbits);
        return nbits / 8;
    endfunction

    function automatic int dm_base(input int nregs);
        return RF_BASE + nregs;
    endfunction

    function automatic int frame_words(input int nregs, input int dm_words);
        return 1 + nregs + dm_words;
    endfunction

endpackage

// File: rtl/debug_word_serializer.sv
// Holds one frame word and hands it to the UART a byte at a time, LSB first.
// The frame FSM in the parent decides when to load, send and wait.
module debug_word_serializer
    import debug_sender_pkg::*;
#(
    parameter int NBITS  = DBG_NBITS,
    parameter int NBYTES = BYTES_PER_WORD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [NBITS-1:0] word,
    input  logic             send,
    input  logic             waiting,
    input  logic             tx_done,
    output logic [7:0]       tx_data,
    output logic             tx_start,
    output logic             byte_done,
    output logic             word_done
);

    localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);

    logic [NBITS-1:0] shift;
    logic [BW-1:0]    byte_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift    <= '0;
            byte_idx <= '0;
        end else if (load) begin
            shift    <= word;
            byte_idx <= '0;
        end else if (byte_done) begin
            shift    <= shift >> 8;
            byte_idx <= (byte_idx == LAST_BYTE) ? '0 : byte_idx + 1'b1;
        end
    end

    // tx_data comes straight off the register, so it cannot move while the
    // UART is busy: the shift only happens on the accepted tx_done.
    assign tx_data   = shift[7:0];
    assign tx_start  = send;
    assign byte_done = waiting & tx_done;
    assign word_done = byte_done & (byte_idx == LAST_BYTE);

endmodule

// File: rtl/debug_sender.sv
// Dumps PC, register file and data memory to the UART on a send_flag request,
// then pulses send_done once and waits for the request to be withdrawn.
//
// state    | meaning
// IDLE     | waiting for send_flag; captures PC on exit
// LOAD     | addresses valid, latch selected word into serializer
// SEND     | tx_start pulse for the current byte
// WAIT_TX  | byte in flight, waiting for tx_done
// DONE     | send_done pulse
// WAIT_LOW | frame finished, waiting for send_flag to drop
module debug_sender
    import debug_sender_pkg::*;
#(
    parameter int NBITS          = DBG_NBITS,
    parameter int NREGS          = DBG_NREGS,
    parameter int RF_ADDR_LENGTH = 5,
    parameter int DM_WORDS       = DBG_DM_WORDS,
    parameter int DM_ADDR_LENGTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      send_flag,
    input  logic [NBITS-1:0]          pc_value,
    input  logic [NBITS-1:0]          rf_data,
    input  logic [NBITS-1:0]          dm_data,
    input  logic                      tx_done,
    output logic [RF_ADDR_LENGTH-1:0] rf_addr,
    output logic [DM_ADDR_LENGTH-1:0] dm_addr,
    output logic [7:0]                tx_data,
    output logic                      tx_start,
    output logic                      send_done
);

    localparam int W     = frame_words(NREGS, DM_WORDS);
    localparam int IDX_W = $clog2(W) + 1;

    localparam logic [IDX_W-1:0] PC_WORD  = IDX_W'(PC_IDX);
    localparam logic [IDX_W-1:0] RF_FIRST = IDX_W'(RF_BASE);
    localparam logic [IDX_W-1:0] DM_FIRST = IDX_W'(dm_base(NREGS));
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);

    dbg_state_e state, state_nxt;

    logic [IDX_W-1:0]          word_idx, word_idx_nxt;
    logic [NBITS-1:0]          pc_hold;
    logic [NBITS-1:0]          word_sel;
    logic [RF_ADDR_LENGTH-1:0] rf_addr_nxt;
    logic [DM_ADDR_LENGTH-1:0] dm_addr_nxt;
    logic                      load;
    logic                      byte_done;
    logic                      word_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            word_idx <= '0;
            pc_hold  <= '0;
            rf_addr  <= '0;
            dm_addr  <= '0;
        end else begin
            state    <= state_nxt;
            word_idx <= word_idx_nxt;
            if (state == ST_IDLE && send_flag)
                pc_hold <= pc_value;
            // Addresses are registered on entry to LOAD so the memories'
            // combinational read data is settled during the LOAD cycle.
            if (state_nxt == ST_LOAD) begin
                rf_addr <= rf_addr_nxt;
                dm_addr <= dm_addr_nxt;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        word_idx_nxt = word_idx;
        load         = 1'b0;
        send_done    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (send_flag) begin
                    state_nxt    = ST_LOAD;
                    word_idx_nxt = '0;
                end
            end
            ST_LOAD: begin
                load      = 1'b1;
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                state_nxt = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (word_done) begin
                    if (word_idx == LAST_IDX) begin
                        state_nxt = ST_DONE;
                    end else begin
                        word_idx_nxt = word_idx + 1'b1;
                        state_nxt    = ST_LOAD;
                    end
                end else if (byte_done) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_DONE: begin
                send_done = 1'b1;
                state_nxt = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!send_flag)
                    state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rf_addr_nxt = '0;
        dm_addr_nxt = '0;
        if (word_idx_nxt >= DM_FIRST)
            dm_addr_nxt = DM_ADDR_LENGTH'(word_idx_nxt - DM_FIRST);
        else if (word_idx_nxt >= RF_FIRST)
            rf_addr_nxt = RF_ADDR_LENGTH'(word_idx_nxt - RF_FIRST);
    end

    always_comb begin
        if (word_idx == PC_WORD)
            word_sel = pc_hold;
        else if (word_idx < DM_FIRST)
            word_sel = rf_data;
        else
            word_sel = dm_data;
    end

    debug_word_serializer #(
        .NBITS  (NBITS),
        .NBYTES (bytes_per_word(NBITS))
    ) u_serializer (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .word      (word_sel),
        .send      (state == ST_SEND),
        .waiting   (state == ST_WAIT_TX),
        .tx_done   (tx_done),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .byte_done (byte_done),
        .word_done (word_done)
    );

endmodule

// File: tb/tb_debug_sender.sv
// Scoreboard bench for debug_sender: frame bytes are predicted from memory
// images, a UART model answers each tx_start and a monitor checks order/timing.
module tb_debug_sender;

    localparam int NREGS    = 32;
    localparam int DM_WORDS = 32;
    localparam int W        = 1 + NREGS + DM_WORDS;
    localparam int NB       = 4 * W;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        send_flag = 1'b0;
    logic [31:0] pc_value = '0;
    logic [31:0] rf_data, dm_data;
    logic        tx_done;
    logic [4:0]  rf_addr, dm_addr;
    logic [7:0]  tx_data;
    logic        tx_start, send_done;

    logic [31:0] rf_mem [NREGS];
    logic [31:0] dm_mem [DM_WORDS];
    logic        uart_done = 1'b0;
    logic        spur_done = 1'b0;

    assign tx_done = uart_done | spur_done;
    assign rf_data = rf_mem[rf_addr];
    assign dm_data = dm_mem[dm_addr];

    debug_sender dut (
        .clk       (clk),
        .reset     (reset),
        .send_flag (send_flag),
        .pc_value  (pc_value),
        .rf_data   (rf_data),
        .dm_data   (dm_data),
        .tx_done   (tx_done),
        .rf_addr   (rf_addr),
        .dm_addr   (dm_addr),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .send_done (send_done)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] exp_q [$];
    logic [7:0] rx [NB];
    int         byte_pos = 0;
    int         frame_bytes = 0;
    int         flag_cycle = 0;
    int         done_cycle = 0;
    int         sd_count = 0;
    int         tx_count = 0;
    int         busy = 0;
    int         cnt = 0;
    logic [7:0] cur_byte = '0;
    bit         rand_delay = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endfunction

    // Monitor + UART model: answers each byte after a delay, scores bytes and timing.
    always @(negedge clk) begin
        uart_done = 1'b0;
        if (!reset) begin
            busy     = 0;
            byte_pos = 0;
            exp_q.delete();
        end else begin
            if (busy != 0) begin
                chk("tx_data_stable", {24'd0, tx_data}, {24'd0, cur_byte});
                cnt--;
                if (cnt == 0) begin
                    uart_done  = 1'b1;
                    busy       = 0;
                    done_cycle = cycle;
                end
            end
            if (send_done === 1'b1) begin
                sd_count++;
                chk("done_gap", cycle - done_cycle, 1);
                chk("done_bytes_left", exp_q.size(), 0);
                frame_bytes = byte_pos;
                byte_pos    = 0;
            end
            if (tx_start === 1'b1) begin
                tx_count++;
                chk("tx_start_while_busy", busy, 0);
                chk("tx_start_expected", {31'd0, exp_q.size() > 0}, 1);
                if (exp_q.size() > 0)
                    chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                if (byte_pos == 0)
                    chk("first_latency", cycle - flag_cycle, 2);
                else
                    chk("tx_gap", cycle - done_cycle, (byte_pos % 4 == 0) ? 2 : 1);
                if (byte_pos < NB)
                    rx[byte_pos] = tx_data;
                byte_pos++;
                busy     = 1;
                cnt      = rand_delay ? int'($urandom_range(1, 6)) : 10;
                cur_byte = tx_data;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic push_frame();
        logic [31:0] w;
        for (int i = 0; i < W; i++) begin
            if (i == 0)
                w = pc_value;
            else if (i <= NREGS)
                w = rf_mem[i-1];
            else
                w = dm_mem[i-1-NREGS];
            for (int b = 0; b < 4; b++)
                exp_q.push_back(w[8*b +: 8]);
        end
    endtask

    task automatic randomize_images();
        pc_value = $urandom;
        for (int i = 0; i < NREGS; i++) rf_mem[i] = $urandom;
        for (int i = 0; i < DM_WORDS; i++) dm_mem[i] = $urandom;
    endtask

    task automatic start_frame();
        push_frame();
        send_flag  = 1'b1;
        flag_cycle = cycle;
    endtask

    task automatic wait_frame(input string name);
        int s;
        int t;
        s = sd_count;
        t = 0;
        while (sd_count == s && t < 20000) begin
            step();
            t++;
        end
        repeat (3) step();
        chk({name, "_send_done_pulses"}, sd_count - s, 1);
        chk({name, "_bytes"}, frame_bytes, NB);
    endtask

    task automatic wait_byte(input int n);
        int t;
        t = 0;
        while (byte_pos < n && t < 20000) begin
            step();
            t++;
        end
        chk("reached_byte", {31'd0, byte_pos >= n}, 1);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_tx_start"}, {31'd0, tx_start}, 0);
        chk({name, "_send_done"}, {31'd0, send_done}, 0);
        chk({name, "_tx_data"}, {24'd0, tx_data}, 0);
        chk({name, "_rf_addr"}, {27'd0, rf_addr}, 0);
        chk({name, "_dm_addr"}, {27'd0, dm_addr}, 0);
    endtask

    initial begin
        int tc;
        int sd_before;

        pc_value = 32'h0000_0040;
        for (int i = 0; i < NREGS; i++) rf_mem[i] = 32'h100 + i;
        for (int i = 0; i < DM_WORDS; i++) dm_mem[i] = 32'hA000 + i;

        repeat (3) step();
        check_idle_outputs("reset");
        reset = 1'b1;
        repeat (2) step();

        spur_done = 1'b1;
        step();
        spur_done = 1'b0;
        repeat (2) step();
        chk("idle_spurious_no_tx", tx_count, 0);

        // Fixed-pattern frame with a 10-cycle UART.
        start_frame();
        repeat (3) step();
        pc_value = $urandom;
        wait_frame("frame_a");
        chk("a_b0", {24'd0, rx[0]}, 32'h40);
        chk("a_b1", {24'd0, rx[1]}, 32'h00);
        chk("a_b3", {24'd0, rx[3]}, 32'h00);
        chk("a_b4", {24'd0, rx[4]}, 32'h00);
        chk("a_b5", {24'd0, rx[5]}, 32'h01);
        chk("a_b6", {24'd0, rx[6]}, 32'h00);
        chk("a_b256", {24'd0, rx[NB-4]}, 32'h1F);
        chk("a_b257", {24'd0, rx[NB-3]}, 32'hA0);
        chk("a_b258", {24'd0, rx[NB-2]}, 32'h00);
        chk("a_b259", {24'd0, rx[NB-1]}, 32'h00);

        // Request held high past send_done must not re-trigger.
        tc = tx_count;
        repeat (3) step();
        chk("no_retrigger_high", tx_count - tc, 0);
        send_flag = 1'b0;
        repeat (3) step();
        chk("no_retrigger_low", tx_count - tc, 0);

        // Random images, random UART delay, spurious tx_done in LOAD, flag drop at byte 50.
        randomize_images();
        rand_delay = 1'b1;
        start_frame();
        step();
        spur_done = 1'b1;
        step();
        spur_done = 1'b0;
        wait_byte(50);
        send_flag = 1'b0;
        wait_frame("frame_b");
        tc = tx_count;
        repeat (5) step();
        chk("after_drop_quiet", tx_count - tc, 0);

        // Reset during byte 100, then restart with send_flag still high.
        randomize_images();
        start_frame();
        wait_byte(101);
        sd_before = sd_count;
        reset = 1'b0;
        #1;
        check_idle_outputs("midreset");
        repeat (2) step();
        push_frame();
        reset      = 1'b1;
        flag_cycle = cycle;
        wait_frame("frame_c");
        chk("midreset_no_partial_done", sd_count - sd_before, 1);
        send_flag = 1'b0;
        repeat (3) step();

        // One more fully random frame to confirm clean return to IDLE.
        randomize_images();
        start_frame();
        wait_frame("frame_d");
        send_flag = 1'b0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
